// File: rtl/opb_simple_master_if.sv
// ---------------------------------------------------------------------------
// opb_simple_master_if
//   Signal bundle for opb_simple_master. It carries the user command/response
//   handshake and the OPB master-port signals. Clock and reset stay outside
//   the bundle.
//
//   Modports
//     master : the view from inside opb_simple_master
//              (drives cmd_ready, rsp_*, M_*)
//     slave  : the view from the user logic and the arbiter/slave side
//              (drives cmd_*, rsp_ready, OPB_*)
//
//   Signals (bit 0 is the MSB, as usual for OPB)
//     cmd_valid, cmd_ready, cmd_rnw, cmd_addr, cmd_be, cmd_data
//                              : single-beat command handshake
//     rsp_valid, rsp_ready, rsp_data, rsp_err
//                              : response handshake
//     M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock
//                              : OPB master outputs
//     OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus
//                              : OPB inputs to the master
// ---------------------------------------------------------------------------
interface opb_simple_master_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  // User command side
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_rnw;
  logic [0:C_OPB_AWIDTH-1]       cmd_addr;
  logic [0:C_OPB_DWIDTH/8-1]     cmd_be;
  logic [0:C_OPB_DWIDTH-1]       cmd_data;

  // User response side
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [0:C_OPB_DWIDTH-1]       rsp_data;
  logic                          rsp_err;

  // OPB master outputs
  logic                          M_request;
  logic                          M_select;
  logic                          M_RNW;
  logic [0:C_OPB_AWIDTH-1]       M_ABus;
  logic [0:C_OPB_DWIDTH/8-1]     M_BE;
  logic [0:C_OPB_DWIDTH-1]       M_DBus;
  logic                          M_seqAddr;
  logic                          M_busLock;

  // OPB inputs
  logic                          OPB_MGrant;
  logic                          OPB_xferAck;
  logic                          OPB_errAck;
  logic                          OPB_retry;
  logic                          OPB_toutSup;
  logic [0:C_OPB_DWIDTH-1]       OPB_DBus;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data, rsp_ready,
    input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data, rsp_ready,
    output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock
  );
endinterface

// File: rtl/opb_simple_master.sv
// ---------------------------------------------------------------------------
// opb_simple_master
//   OPB bus initiator. It accepts one single-beat read or write command from
//   fabric logic, runs it as an OPB master transaction (request, grant,
//   select, ack) and returns a response. Only one command is outstanding at
//   a time.
//
//   Ports
//     OPB_Clk    : clock for the whole block
//     OPB_Rst_n  : asynchronous, active-low reset
//     bus        : opb_simple_master_if.master (command, response and OPB
//                  master-port signals)
//
//   Parameters
//     MAX_RETRY    : OPB_retry occurrences tolerated per command; the next
//                    retry ends the command with rsp_err=1
//     TOUT_CYCLES  : XFER cycles without an ack before a local timeout
//     C_OPB_AWIDTH : address width
//     C_OPB_DWIDTH : data width
//
//   Build option
//     OPB_MASTER_TOUT_EN : when defined, a local XFER timeout counter is
//                          built (held while OPB_toutSup=1). When undefined,
//                          XFER waits indefinitely for an ack or a retry.
//
//   All outputs come from registers. Address, BE, RNW and data buses are
//   forced to 0 whenever M_select=0 so the block can sit on an OR-bus.
// ---------------------------------------------------------------------------
module opb_simple_master #(
  parameter int MAX_RETRY    = 4,
  parameter int TOUT_CYCLES  = 16,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst_n,
  opb_simple_master_if.master bus
);

  localparam int BEW = C_OPB_DWIDTH / 8;
  localparam int RW  = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    m_request_q, m_request_d;
  logic                    m_select_q, m_select_d;
  logic                    m_rnw_q, m_rnw_d;
  logic [0:C_OPB_AWIDTH-1] m_abus_q, m_abus_d;
  logic [0:BEW-1]          m_be_q, m_be_d;
  logic [0:C_OPB_DWIDTH-1] m_dbus_q, m_dbus_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [0:C_OPB_DWIDTH-1] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [RW-1:0]           retry_cnt_q, retry_cnt_d;

  // Latched command; these are data only and need no reset.
  logic                    rnw_q;
  logic [0:C_OPB_AWIDTH-1] addr_q;
  logic [0:BEW-1]          be_q;
  logic [0:C_OPB_DWIDTH-1] wdata_q;

  logic                    latch_en;
  logic                    release_bus;

`ifdef OPB_MASTER_TOUT_EN
  localparam int TW = (TOUT_CYCLES > 1) ? $clog2(TOUT_CYCLES) : 1;
  logic [TW-1:0]           tout_cnt_q, tout_cnt_d;
`else
  // OPB_toutSup only matters for the local timeout.
  logic                    unused_tout_sup;
  assign unused_tout_sup = bus.OPB_toutSup;
`endif

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    m_request_d = m_request_q;
    m_select_d  = m_select_q;
    m_rnw_d     = m_rnw_q;
    m_abus_d    = m_abus_q;
    m_be_d      = m_be_q;
    m_dbus_d    = m_dbus_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    retry_cnt_d = retry_cnt_q;
    latch_en    = 1'b0;
    release_bus = 1'b0;
`ifdef OPB_MASTER_TOUT_EN
    tout_cnt_d  = tout_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid) begin
          latch_en    = 1'b1;
          retry_cnt_d = '0;
          cmd_ready_d = 1'b0;
          m_request_d = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (bus.OPB_MGrant) begin
          m_request_d = 1'b0;
          m_select_d  = 1'b1;
          m_rnw_d     = rnw_q;
          m_abus_d    = addr_q;
          m_be_d      = be_q;
          // The data bus stays 0 during reads so it cannot corrupt the OR-bus.
          m_dbus_d    = rnw_q ? '0 : wdata_q;
`ifdef OPB_MASTER_TOUT_EN
          tout_cnt_d  = '0;
`endif
          state_d     = XFER;
        end
      end

      XFER: begin
        if (bus.OPB_errAck) begin
          release_bus = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = RSP;
        end else if (bus.OPB_xferAck) begin
          release_bus = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = rnw_q ? bus.OPB_DBus : '0;
          state_d     = RSP;
        end else if (bus.OPB_retry) begin
          release_bus = 1'b1;
          if (retry_cnt_q < RW'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            m_request_d = 1'b1;
            state_d     = REQ;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = RSP;
          end
`ifdef OPB_MASTER_TOUT_EN
        end else if (!bus.OPB_toutSup && (tout_cnt_q == TW'(TOUT_CYCLES - 1))) begin
          release_bus = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = RSP;
        end else if (!bus.OPB_toutSup) begin
          tout_cnt_d  = tout_cnt_q + TW'(1);
`endif
        end
      end

      RSP: begin
        // Response stays stable until accepted; cmd_ready returns on the
        // same edge so the next command can be taken one cycle later.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Leaving XFER: deselect and return every driven bus to 0 on the same edge.
    if (release_bus) begin
      m_select_d = 1'b0;
      m_rnw_d    = 1'b0;
      m_abus_d   = '0;
      m_be_d     = '0;
      m_dbus_d   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      m_request_q <= 1'b0;
      m_select_q  <= 1'b0;
      m_rnw_q     <= 1'b0;
      m_abus_q    <= '0;
      m_be_q      <= '0;
      m_dbus_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      m_request_q <= m_request_d;
      m_select_q  <= m_select_d;
      m_rnw_q     <= m_rnw_d;
      m_abus_q    <= m_abus_d;
      m_be_q      <= m_be_d;
      m_dbus_q    <= m_dbus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

`ifdef OPB_MASTER_TOUT_EN
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      tout_cnt_q <= '0;
    end else begin
      tout_cnt_q <= tout_cnt_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Command capture (command inputs may change freely after accept)
  // -------------------------------------------------------------------------
  always_ff @(posedge OPB_Clk) begin
    if (latch_en) begin
      rnw_q   <= bus.cmd_rnw;
      addr_q  <= bus.cmd_addr;
      be_q    <= bus.cmd_be;
      wdata_q <= bus.cmd_data;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.M_request = m_request_q;
  assign bus.M_select  = m_select_q;
  assign bus.M_RNW     = m_rnw_q;
  assign bus.M_ABus    = m_abus_q;
  assign bus.M_BE      = m_be_q;
  assign bus.M_DBus    = m_dbus_q;
  assign bus.M_seqAddr = 1'b0;
  assign bus.M_busLock = 1'b0;

endmodule

// File: tb/tb_opb_simple_master.sv
// ---------------------------------------------------------------------------
// tb_opb_simple_master
//   Directed bench for opb_simple_master. A table of command/slave-behaviour
//   records with hand-computed responses is applied in a loop, followed by
//   hand-written sequences for reset, response back-pressure, stray grants
//   and (when OPB_MASTER_TOUT_EN is defined) the local timeout.
// ---------------------------------------------------------------------------
module tb_opb_simple_master;

  localparam int MAXR = 4;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  opb_simple_master_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus_if ();

  opb_simple_master #(
    .MAX_RETRY   (MAXR),
    .TOUT_CYCLES (16),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32)
  ) dut (
    .OPB_Clk  (clk),
    .OPB_Rst_n(rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gdly;     // idle cycles before grant on every attempt
    int          adly;     // extra select cycles before the final response
    int          nretry;   // attempts answered with OPB_retry
    logic        ea;       // errAck on the final attempt
    logic        xa;       // xferAck on the final attempt
    logic [31:0] sd;       // slave data on OPB_DBus during the ack cycle
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_rnw     = 1'b0;
    bus_if.cmd_addr    = '0;
    bus_if.cmd_be      = '0;
    bus_if.cmd_data    = '0;
    bus_if.rsp_ready   = 1'b0;
    bus_if.OPB_MGrant  = 1'b0;
    bus_if.OPB_xferAck = 1'b0;
    bus_if.OPB_errAck  = 1'b0;
    bus_if.OPB_retry   = 1'b0;
    bus_if.OPB_toutSup = 1'b0;
    bus_if.OPB_DBus    = '0;
  endtask

  // Issue a command and see it accepted; afterwards scramble the command
  // inputs to show the latched copy is what reaches the bus.
  task automatic issue(input logic rnw, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data, input string tag);
    bus_if.cmd_rnw   = rnw;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_be    = be;
    bus_if.cmd_data  = data;
    bus_if.cmd_valid = 1'b1;
    check({tag, "_cmd_ready_pre"}, 32'(bus_if.cmd_ready), 32'd1);
    tick();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rnw   = ~rnw;
    bus_if.cmd_addr  = ~addr;
    bus_if.cmd_be    = ~be;
    bus_if.cmd_data  = ~data;
    check({tag, "_cmd_ready_post"}, 32'(bus_if.cmd_ready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    int    attempts;
    t = $sformatf("v%0d", idx);
    attempts = (v.nretry > MAXR) ? MAXR + 1 : v.nretry + 1;
    issue(v.rnw, v.addr, v.be, v.wdata, t);
    for (int a = 0; a < attempts; a++) begin
      check({t, "_req"}, 32'(bus_if.M_request), 32'd1);
      check({t, "_sel_idle"}, 32'(bus_if.M_select), 32'd0);
      for (int g = 0; g < v.gdly; g++) begin
        tick();
        check({t, "_abus_wait"}, bus_if.M_ABus, 32'd0);
      end
      bus_if.OPB_MGrant = 1'b1;
      tick();
      bus_if.OPB_MGrant = 1'b0;
      check({t, "_req_drop"}, 32'(bus_if.M_request), 32'd0);
      for (int k = 0; k <= v.adly; k++) begin
        check({t, "_sel"}, 32'(bus_if.M_select), 32'd1);
        check({t, "_abus"}, bus_if.M_ABus, v.addr);
        check({t, "_be"}, 32'(bus_if.M_BE), 32'(v.be));
        check({t, "_rnw"}, 32'(bus_if.M_RNW), 32'(v.rnw));
        check({t, "_dbus"}, bus_if.M_DBus, v.rnw ? 32'd0 : v.wdata);
        if (k == v.adly) begin
          if (a < v.nretry) begin
            bus_if.OPB_retry = 1'b1;
          end else begin
            bus_if.OPB_xferAck = v.xa;
            bus_if.OPB_errAck  = v.ea;
            bus_if.OPB_DBus    = v.sd;
          end
        end
        tick();
      end
      bus_if.OPB_retry   = 1'b0;
      bus_if.OPB_xferAck = 1'b0;
      bus_if.OPB_errAck  = 1'b0;
      bus_if.OPB_DBus    = '0;
      check({t, "_sel_rel"}, 32'(bus_if.M_select), 32'd0);
      check({t, "_abus_rel"}, bus_if.M_ABus, 32'd0);
      check({t, "_dbus_rel"}, bus_if.M_DBus, 32'd0);
      check({t, "_be_rel"}, 32'(bus_if.M_BE), 32'd0);
    end
    check({t, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
    check({t, "_rsp_err"}, 32'(bus_if.rsp_err), 32'(v.exp_err));
    check({t, "_rsp_data"}, bus_if.rsp_data, v.exp_data);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    check({t, "_rsp_done"}, 32'(bus_if.rsp_valid), 32'd0);
    check({t, "_cmd_ready_back"}, 32'(bus_if.cmd_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            rnw   addr          be    wdata         gd ad nr ea    xa    sd            err   data
    vecs[0] = '{1'b0, 32'h010C_0000, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h010C_0004, 4'hF, 32'h0,         0, 2, 0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h010C_0008, 4'hF, 32'h0,         1, 0, 4, 1'b0, 1'b1, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F};
    vecs[3] = '{1'b0, 32'h010C_000C, 4'hF, 32'h0BAD_F00D, 0, 0, 5, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h010C_0010, 4'hF, 32'h0,         0, 1, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0010, 4'h3, 32'h0000_CAFE, 2, 0, 0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h8000_0000, 4'h8, 32'h0,         0, 0, 1, 1'b1, 1'b0, 32'h7777_7777, 1'b1, 32'h0};

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_request", 32'(bus_if.M_request), 32'd0);
    check("rst_select", 32'(bus_if.M_select), 32'd0);
    check("rst_abus", bus_if.M_ABus, 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_tied", {30'd0, bus_if.M_seqAddr, bus_if.M_busLock}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Stray grant while idle must not select the bus.
    bus_if.OPB_MGrant = 1'b1;
    tick();
    tick();
    bus_if.OPB_MGrant = 1'b0;
    check("stray_grant_sel", 32'(bus_if.M_select), 32'd0);
    check("stray_grant_abus", bus_if.M_ABus, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      tick();
    end

    // Response back-pressure: held response, no new command while pending.
    issue(1'b1, 32'h0000_0040, 4'hF, 32'h0, "hold");
    bus_if.OPB_MGrant = 1'b1;
    tick();
    bus_if.OPB_MGrant  = 1'b0;
    bus_if.OPB_xferAck = 1'b1;
    bus_if.OPB_DBus    = 32'hC0DE_0042;
    tick();
    bus_if.OPB_xferAck = 1'b0;
    bus_if.OPB_DBus    = '0;
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_rnw     = 1'b0;
    bus_if.cmd_addr    = 32'h0000_0080;
    repeat (3) tick();
    check("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("hold_rsp_data", bus_if.rsp_data, 32'hC0DE_0042);
    check("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    check("hold_request", 32'(bus_if.M_request), 32'd0);
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    check("hold_cmd_ready_hs", 32'(bus_if.cmd_ready), 32'd0);
    tick();
    bus_if.rsp_ready = 1'b0;
    check("hold_cmd_ready_after", 32'(bus_if.cmd_ready), 32'd1);
    check("hold_rsp_cleared", 32'(bus_if.rsp_valid), 32'd0);
    tick();

    // Asynchronous reset in the middle of XFER.
    issue(1'b0, 32'h0000_0100, 4'hF, 32'h1357_9BDF, "arst");
    bus_if.OPB_MGrant = 1'b1;
    tick();
    bus_if.OPB_MGrant = 1'b0;
    check("arst_sel_before", 32'(bus_if.M_select), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(bus_if.M_select), 32'd0);
    check("arst_abus", bus_if.M_ABus, 32'd0);
    check("arst_dbus", bus_if.M_DBus, 32'd0);
    check("arst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    check("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("arst_request", 32'(bus_if.M_request), 32'd0);

`ifdef OPB_MASTER_TOUT_EN
    // No ack at all: timeout after 16 XFER cycles.
    issue(1'b1, 32'h0000_0200, 4'hF, 32'h0, "tout");
    bus_if.OPB_MGrant = 1'b1;
    tick();
    bus_if.OPB_MGrant = 1'b0;
    repeat (15) tick();
    check("tout_sel_15", 32'(bus_if.M_select), 32'd1);
    tick();
    check("tout_sel_16", 32'(bus_if.M_select), 32'd0);
    check("tout_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("tout_rsp_err", 32'(bus_if.rsp_err), 32'd1);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;

    // toutSup for the first 10 cycles, ack on XFER cycle 20.
    issue(1'b1, 32'h0000_0204, 4'hF, 32'h0, "tsup");
    bus_if.OPB_MGrant = 1'b1;
    tick();
    bus_if.OPB_MGrant  = 1'b0;
    bus_if.OPB_toutSup = 1'b1;
    repeat (10) tick();
    bus_if.OPB_toutSup = 1'b0;
    repeat (9) tick();
    check("tsup_sel_19", 32'(bus_if.M_select), 32'd1);
    bus_if.OPB_xferAck = 1'b1;
    bus_if.OPB_DBus    = 32'h0F0F_1234;
    tick();
    bus_if.OPB_xferAck = 1'b0;
    bus_if.OPB_DBus    = '0;
    check("tsup_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("tsup_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    check("tsup_rsp_data", bus_if.rsp_data, 32'h0F0F_1234);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
